// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: T-state enum,
// instruction opcodes, ctrl strobe bit positions and opcode classification.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY  = 2'd0,
        CLS_UNARY   = 2'd1,
        CLS_MULDIV  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int CTRL_W       = 14;
    localparam int CTRL_PC_OUT  = 0;
    localparam int CTRL_PC_IN   = 1;
    localparam int CTRL_PC_INC  = 2;
    localparam int CTRL_MAR_IN  = 3;
    localparam int CTRL_READ    = 4;
    localparam int CTRL_MDR_IN  = 5;
    localparam int CTRL_MDR_OUT = 6;
    localparam int CTRL_IR_IN   = 7;
    localparam int CTRL_Y_IN    = 8;
    localparam int CTRL_Z_IN    = 9;
    localparam int CTRL_ZLO_OUT = 10;
    localparam int CTRL_ZHI_OUT = 11;
    localparam int CTRL_LO_IN   = 12;
    localparam int CTRL_HI_IN   = 13;

    function automatic op_class_e op_class(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_BINARY;
            OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
            default:                         op_class = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// 4-to-16 one-hot register select decoder; all-zero output when not enabled.
module reg_decoder_4to16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    // One-hot decode of the register index
    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = 16'h0000;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer: fetch (T0-T2) then a per-class execute
// sequence; all outputs are Moore decodes of the state register and ir.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              stop,
    input  logic              mem_ready,
    input  logic [31:0]       ir,
    output logic [CTRL_W-1:0] ctrl,
    output logic [15:0]       r_in,
    output logic [15:0]       r_out,
    output logic [4:0]        op_code,
    output logic              halted,
    output logic              illegal
);

    state_e      state_q, state_d;
    logic        t1_hold_q, t1_hold_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  opcode_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    op_class_e   cls_s;
    state_e      last_next_s;
    logic        r_in_en_s, r_out_en_s;
    logic [3:0]  r_in_sel_s, r_out_sel_s;
    logic        unused_ir_s;

    assign opcode_s    = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign unused_ir_s = ^ir[14:0];
    assign cls_s       = op_class(opcode_s);
    assign last_next_s = stop ? S_HALT : (run ? S_T0 : S_IDLE);

    // State, T1-wait and sticky-illegal registers; clr overrides everything
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            t1_hold_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_hold_q <= t1_hold_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing; the execute length depends on the opcode class
    always_comb begin
        state_d   = state_q;
        t1_hold_d = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d   = S_T0;
                    illegal_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else begin
                    state_d   = S_T1;
                    t1_hold_d = 1'b1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (cls_s == CLS_ILLEGAL) begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: begin
                if (cls_s == CLS_UNARY) begin
                    state_d = last_next_s;
                end else begin
                    state_d = S_T5;
                end
            end
            S_T5: begin
                if (cls_s == CLS_BINARY) begin
                    state_d = last_next_s;
                end else begin
                    state_d = S_T6;
                end
            end
            S_T6:    state_d = last_next_s;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe, register-select and ALU-op decode of the current T-state
    always_comb begin
        ctrl        = '0;
        r_in_en_s   = 1'b0;
        r_in_sel_s  = 4'd0;
        r_out_en_s  = 1'b0;
        r_out_sel_s = 4'd0;
        op_code     = 5'd0;
        case (state_q)
            S_T0: begin
                ctrl[CTRL_PC_OUT] = 1'b1;
                ctrl[CTRL_PC_INC] = 1'b1;
                ctrl[CTRL_MAR_IN] = 1'b1;
                ctrl[CTRL_Z_IN]   = 1'b1;
            end
            S_T1: begin
                ctrl[CTRL_READ]   = 1'b1;
                ctrl[CTRL_MDR_IN] = 1'b1;
                // PC reload from Z happens once, not on every wait cycle
                if (!t1_hold_q) begin
                    ctrl[CTRL_ZLO_OUT] = 1'b1;
                    ctrl[CTRL_PC_IN]   = 1'b1;
                end else begin
                    ctrl[CTRL_ZLO_OUT] = 1'b0;
                    ctrl[CTRL_PC_IN]   = 1'b0;
                end
            end
            S_T2: begin
                ctrl[CTRL_MDR_OUT] = 1'b1;
                ctrl[CTRL_IR_IN]   = 1'b1;
            end
            S_T3: begin
                case (cls_s)
                    CLS_BINARY: begin
                        r_out_en_s      = 1'b1;
                        r_out_sel_s     = rb_s;
                        ctrl[CTRL_Y_IN] = 1'b1;
                    end
                    CLS_UNARY: begin
                        r_out_en_s      = 1'b1;
                        r_out_sel_s     = rb_s;
                        ctrl[CTRL_Z_IN] = 1'b1;
                        op_code         = opcode_s;
                    end
                    CLS_MULDIV: begin
                        r_out_en_s      = 1'b1;
                        r_out_sel_s     = ra_s;
                        ctrl[CTRL_Y_IN] = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    CLS_BINARY: begin
                        r_out_en_s      = 1'b1;
                        r_out_sel_s     = rc_s;
                        ctrl[CTRL_Z_IN] = 1'b1;
                        op_code         = opcode_s;
                    end
                    CLS_UNARY: begin
                        r_in_en_s          = 1'b1;
                        r_in_sel_s         = ra_s;
                        ctrl[CTRL_ZLO_OUT] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        r_out_en_s      = 1'b1;
                        r_out_sel_s     = rb_s;
                        ctrl[CTRL_Z_IN] = 1'b1;
                        op_code         = opcode_s;
                    end
                    default: ctrl = '0;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    CLS_BINARY: begin
                        r_in_en_s          = 1'b1;
                        r_in_sel_s         = ra_s;
                        ctrl[CTRL_ZLO_OUT] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl[CTRL_ZLO_OUT] = 1'b1;
                        ctrl[CTRL_LO_IN]   = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            S_T6: begin
                if (cls_s == CLS_MULDIV) begin
                    ctrl[CTRL_ZHI_OUT] = 1'b1;
                    ctrl[CTRL_HI_IN]   = 1'b1;
                end else begin
                    ctrl = '0;
                end
            end
            default: ctrl = '0;
        endcase
    end

    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

    reg_decoder_4to16 u_rin_dec (
        .en     (r_in_en_s),
        .sel    (r_in_sel_s),
        .onehot (r_in)
    );

    reg_decoder_4to16 u_rout_dec (
        .en     (r_out_en_s),
        .sel    (r_out_sel_s),
        .onehot (r_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: instruction-step reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_control_sequencer;

    logic        clk, clr, run, stop, mem_ready;
    logic [31:0] ir;
    logic [13:0] ctrl;
    logic [15:0] r_in, r_out;
    logic [4:0]  op_code;
    logic        halted, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 idle, 1 running instruction, 2 halted; k = cycle index from T0
    int m_mode  = 0;
    int m_k     = 0;
    bit m_hold  = 0;
    bit m_ill   = 0;
    bit m_valid = 0;

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .stop(stop), .mem_ready(mem_ready),
        .ir(ir), .ctrl(ctrl), .r_in(r_in), .r_out(r_out), .op_code(op_code),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 binary, 1 unary, 2 mul/div, 3 undefined
    function automatic int cls_of(input logic [4:0] opc);
        int v;
        v = int'(opc);
        if (v >= 3 && v <= 11) return 0;
        if (v == 17 || v == 18) return 1;
        if (v == 15 || v == 16) return 2;
        return 3;
    endfunction

    function automatic int len_of(input int cls);
        if (cls == 0) return 6;
        if (cls == 1) return 5;
        if (cls == 2) return 7;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int cls;
        cls = cls_of(ir[31:27]);
        if (clr) begin
            m_mode = 0; m_k = 0; m_hold = 0; m_ill = 0;
        end else if (m_mode == 0) begin
            if (run) begin
                m_mode = 1; m_k = 0; m_hold = 0; m_ill = 0;
            end
        end else if (m_mode == 1) begin
            if (m_k == 1 && !mem_ready) begin
                m_hold = 1;
            end else begin
                m_hold = 0;
                if (m_k == 3 && cls == 3) begin
                    m_mode = 0; m_ill = 1;
                end else if (m_k == len_of(cls) - 1) begin
                    if (stop)     m_mode = 2;
                    else if (run) m_k = 0;
                    else          m_mode = 0;
                end else begin
                    m_k++;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [13:0] c;
        logic [15:0] ri, ro;
        logic [4:0]  op;
        int cls, ra, rb, rc;
        c = '0; ri = '0; ro = '0; op = '0;
        cls = cls_of(ir[31:27]);
        ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        if (m_mode == 1) begin
            if (m_k == 0) begin
                c[0] = 1; c[2] = 1; c[3] = 1; c[9] = 1;
            end else if (m_k == 1) begin
                c[4] = 1; c[5] = 1;
                if (!m_hold) begin c[1] = 1; c[10] = 1; end
            end else if (m_k == 2) begin
                c[6] = 1; c[7] = 1;
            end else if (cls == 0) begin
                if (m_k == 3) begin ro[rb] = 1; c[8] = 1; end
                if (m_k == 4) begin ro[rc] = 1; c[9] = 1; op = ir[31:27]; end
                if (m_k == 5) begin ri[ra] = 1; c[10] = 1; end
            end else if (cls == 1) begin
                if (m_k == 3) begin ro[rb] = 1; c[9] = 1; op = ir[31:27]; end
                if (m_k == 4) begin ri[ra] = 1; c[10] = 1; end
            end else if (cls == 2) begin
                if (m_k == 3) begin ro[ra] = 1; c[8] = 1; end
                if (m_k == 4) begin ro[rb] = 1; c[9] = 1; op = ir[31:27]; end
                if (m_k == 5) begin c[10] = 1; c[12] = 1; end
                if (m_k == 6) begin c[11] = 1; c[13] = 1; end
            end
        end
        chk("model_ctrl",    32'(ctrl),    32'(c));
        chk("model_r_in",    32'(r_in),    32'(ri));
        chk("model_r_out",   32'(r_out),   32'(ro));
        chk("model_op_code", 32'(op_code), 32'(op));
        chk("model_halted",  32'(halted),  32'(m_mode == 2));
        chk("model_illegal", 32'(illegal), 32'(m_ill));
    endtask

    // advance one clock: model sees the same inputs as the DUT edge, then check
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) model_check();
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] c);
        return {opc, a, b, c, 15'd0};
    endfunction

    initial begin
        logic [4:0] legal_ops [13];
        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                      5'd15, 5'd16, 5'd17, 5'd18};

        clr = 1; run = 0; stop = 0; mem_ready = 1; ir = 32'd0;
        tick();
        m_valid = 1;
        chk("reset_ctrl",  32'(ctrl), 32'h0);
        chk("reset_rin",   32'(r_in), 32'h0);
        chk("reset_rout",  32'(r_out), 32'h0);
        chk("reset_flags", {30'd0, halted, illegal}, 32'h0);

        // shl R4 <- R3 << R9, back-to-back
        clr = 0; run = 1; ir = 32'h5A1C8000;
        tick(); chk("shl_t0_ctrl", 32'(ctrl), 32'h020D);
        tick(); chk("shl_t1_ctrl", 32'(ctrl), 32'h0432);
        tick(); chk("shl_t2_ctrl", 32'(ctrl), 32'h00C0);
        tick(); chk("shl_t3_rout", 32'(r_out), 32'h0008); chk("shl_t3_ctrl", 32'(ctrl), 32'h0100);
        tick(); chk("shl_t4_rout", 32'(r_out), 32'h0200); chk("shl_t4_op", 32'(op_code), 32'h0B);
        tick(); chk("shl_t5_rin", 32'(r_in), 32'h0010); chk("shl_t5_ctrl", 32'(ctrl), 32'h0400);
        tick(); chk("shl_next_t0", 32'(ctrl), 32'h020D);

        // memory wait: three not-ready edges in T1
        mem_ready = 0;
        tick(); chk("wait_t1_first", 32'(ctrl), 32'h0432);
        tick(); chk("wait_t1_2", 32'(ctrl), 32'h0030);
        tick(); chk("wait_t1_3", 32'(ctrl), 32'h0030);
        tick(); chk("wait_t1_4", 32'(ctrl), 32'h0030);
        mem_ready = 1;
        tick(); chk("wait_t2", 32'(ctrl), 32'h00C0);
        tick(); tick(); tick();
        stop = 1;
        tick(); chk("halt_flag", 32'(halted), 32'h1); chk("halt_ctrl", 32'(ctrl), 32'h0);
        stop = 0;
        tick(); tick(); chk("halt_run_ignored", 32'(halted), 32'h1);
        clr = 1;
        tick(); chk("halt_clr", 32'(halted), 32'h0);
        clr = 0;

        // mul R2, R5: seven-cycle instruction
        ir = mk_ir(5'b01111, 4'd2, 4'd5, 4'd0);
        tick(); chk("mul_t0", 32'(ctrl), 32'h020D);
        tick(); tick();
        tick(); chk("mul_t3_rout", 32'(r_out), 32'h0004);
        tick(); chk("mul_t4_rout", 32'(r_out), 32'h0020); chk("mul_t4_op", 32'(op_code), 32'h0F);
        tick(); chk("mul_t5_ctrl", 32'(ctrl), 32'h1400);
        tick(); chk("mul_t6_ctrl", 32'(ctrl), 32'h2800);
        tick(); chk("mul_next_t0", 32'(ctrl), 32'h020D);

        // undefined opcode
        ir = 32'hF800_0000;
        tick(); tick();
        tick(); chk("ill_t3_ctrl", 32'(ctrl), 32'h0); chk("ill_t3_rin", 32'(r_in), 32'h0);
        tick(); chk("ill_flag", 32'(illegal), 32'h1); chk("ill_idle_ctrl", 32'(ctrl), 32'h0);
        ir = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        tick(); chk("ill_cleared", 32'(illegal), 32'h0); chk("ill_restart_t0", 32'(ctrl), 32'h020D);
        tick(); tick(); tick(); tick();
        clr = 1;
        tick(); chk("midclr_ctrl", 32'(ctrl), 32'h0); chk("midclr_rout", 32'(r_out), 32'h0);
        clr = 0;

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            clr       = ($urandom_range(0, 39) == 0);
            run       = ($urandom_range(0, 3) != 0);
            stop      = ($urandom_range(0, 9) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_mode != 1 || m_k <= 2) begin
                if ($urandom_range(0, 3) != 0)
                    ir = mk_ir(legal_ops[$urandom_range(0, 12)], 4'($urandom), 4'($urandom), 4'($urandom));
                else
                    ir = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
